video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Generates the raster timing for the HDMI/DVI output path: hsync, vsync, display-enable, pixel coordinates and frame/line strobes.
- Runs on the 25 MHz pixel clock produced by the video PLL.
- Gates itself on the PLL lock indication, so no partial or garbled frame is emitted while the clock is unstable.
- Feeds the framebuffer reader and the TMDS encoder stage.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CW, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1
LOCK_SETTLE, 1024, pixel clocks synced lock must stay high before raster starts

Ports:
clk  in  1  pixel clock (PLL 25 MHz output)
reset  in  1  asynchronous, active-high reset
pll_locked  in  1  PLL lock flag, treated as asynchronous
hsync  out  1  horizontal sync, polarity per HS_POL
vsync  out  1  vertical sync, polarity per VS_POL
de  out  1  display enable; high during active pixels only
x  out  CW  current pixel column; 0 when de low
y  out  CW  current line; 0 when de low
line_start  out  1  one-cycle pulse at h_cnt==0 in RUN
frame_start  out  1  one-cycle pulse at h_cnt==0 && v_cnt==0 in RUN
running  out  1  high while state is RUN

Behaviour:
- Reset is asynchronous, active-high, on clk; all flops clear immediately.
- Values during reset and outside RUN:
  - hsync = ~HS_POL, vsync = ~VS_POL
  - de = 0, x = 0, y = 0
  - line_start = 0, frame_start = 0, running = 0
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525)
- pll_locked passes through a 2-flop synchronizer (lock_s), reset to 0.
- State machine:
  - WAIT_LOCK (reset state): settle counter = 0. Go to SETTLE when lock_s = 1.
  - SETTLE: settle counter increments each cycle. lock_s = 0 -> WAIT_LOCK and clear counter. Counter == LOCK_SETTLE-1 -> RUN with h_cnt = 0, v_cnt = 0.
  - RUN: h_cnt increments each cycle. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. v_cnt at V_TOTAL-1 wraps to 0 on that same h wrap. lock_s = 0 -> WAIT_LOCK; counters clear next cycle.
- Output decode is registered, 1-cycle latency from counters. All outputs update on the same edge, so they stay mutually aligned.
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - x = h_cnt and y = v_cnt when de, else 0
  - hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vsync active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; changes at the h_cnt==0 boundary only
- First de=1 (x=0, y=0, frame_start=1, line_start=1) occurs 1 cycle after RUN entry.
- Lock loss mid-frame:
  - Outputs return to idle values 3 cycles after pll_locked falls: 2 synchronizer cycles plus 1 output register.
  - No partial-line completion.
- Lock glitch during SETTLE restarts the full LOCK_SETTLE wait.
- Coordinate arithmetic is unsigned CW-bit; counters never exceed TOTAL-1.

Test Plan:
- Reset/idle: reset=1, pll_locked=1 -> hsync=1, vsync=1, de=0, x=0, y=0, running=0. Release reset with pll_locked=0 for 2000 cycles -> outputs stay idle.
- Lock-up (LOCK_SETTLE=4): pll_locked rises at cycle T -> running=1 and first de=1 with x=0, y=0, frame_start=1 at cycle T+2+4+1. Bench checks exact cycle.
- Line timing (defaults): per line de high 640 cycles; hsync low 96 cycles starting 656 cycles after line_start; line_start period 800 cycles.
- Frame timing (defaults): frame_start period 420000 cycles; 480 lines contain de; vsync low for exactly 1600 cycles starting at line 490, h_cnt==0. Last active pixel x=639, y=479.
- Lock loss: drop pll_locked at line 200, x=300 -> idle outputs within 3 cycles. Re-assert -> after settle, restart at x=0, y=0 with frame_start.
- Settle glitch and async reset: pulse pll_locked low for 1 cycle mid-SETTLE -> full settle restarts. Assert reset mid-frame -> all outputs idle immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: hsync/vsync/de, pixel coordinates and line/frame strobes.
// The raster only runs after the synchronised PLL lock has been stable for LOCK_SETTLE clocks.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned CW          = 10,
  parameter int unsigned LOCK_SETTLE = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pll_locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned SW      = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;

  localparam logic [CW-1:0] HMax     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VMax     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HActive  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActive  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HsStart  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HsEnd    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VsStart  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VsEnd    = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SW-1:0] SettleMax = SW'(LOCK_SETTLE - 1);

  typedef enum logic [1:0] {StWaitLock, StSettle, StRun} state_e;

  state_e        state_q;
  logic          lock_meta_q, lock_s_q;
  logic [SW-1:0] settle_q;
  logic [CW-1:0] h_q, v_q;

  logic          hsync_q, vsync_q, de_q, line_start_q, frame_start_q, running_q;
  logic [CW-1:0] x_q, y_q;

  logic          active;
  logic          hsync_d, vsync_d, de_d, line_start_d, frame_start_d, running_d;
  logic [CW-1:0] x_d, y_d;

  // Gating on lock_s as well as state lets outputs go idle on the same edge the FSM leaves RUN.
  always_comb begin
    active        = (state_q == StRun) && lock_s_q;
    de_d          = active && (h_q < HActive) && (v_q < VActive);
    x_d           = de_d ? h_q : '0;
    y_d           = de_d ? v_q : '0;
    hsync_d       = (active && (h_q >= HsStart) && (h_q < HsEnd)) ? HS_POL : ~HS_POL;
    vsync_d       = (active && (v_q >= VsStart) && (v_q < VsEnd)) ? VS_POL : ~VS_POL;
    line_start_d  = active && (h_q == '0);
    frame_start_d = line_start_d && (v_q == '0);
    running_d     = active;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      state_q       <= StWaitLock;
      settle_q      <= '0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      lock_meta_q   <= pll_locked;
      lock_s_q      <= lock_meta_q;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;

      unique case (state_q)
        StWaitLock: begin
          settle_q <= '0;
          h_q      <= '0;
          v_q      <= '0;
          if (lock_s_q) state_q <= StSettle;
        end
        StSettle: begin
          if (!lock_s_q) begin
            state_q  <= StWaitLock;
            settle_q <= '0;
          end else if (settle_q == SettleMax) begin
            state_q  <= StRun;
            settle_q <= '0;
            h_q      <= '0;
            v_q      <= '0;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        StRun: begin
          if (!lock_s_q) begin
            state_q <= StWaitLock;
          end else if (h_q == HMax) begin
            h_q <= '0;
            v_q <= (v_q == VMax) ? '0 : v_q + 1'b1;
          end else begin
            h_q <= h_q + 1'b1;
          end
        end
        default: state_q <= StWaitLock;
      endcase
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen using a reduced raster (30x15) and LOCK_SETTLE=4.
module tb_video_timing_gen;

  localparam int unsigned HA = 16, HF = 4, HSW = 6, HB = 4;
  localparam int unsigned VA = 8, VF = 2, VSW = 2, VB = 3;
  localparam int unsigned LS = 4;
  localparam int unsigned HT = HA + HF + HSW + HB;  // 30
  localparam int unsigned VT = VA + VF + VSW + VB;  // 15
  localparam int unsigned FR = HT * VT;             // 450

  logic       clk, reset, pll_locked;
  logic       hsync, vsync, de, line_start, frame_start, running;
  logic [9:0] x, y;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(10), .LOCK_SETTLE(LS)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .running(running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [26:0] v;
  } exp_t;

  exp_t q[$];
  exp_t e;

  // Packed order: {hsync, vsync, de, x, y, line_start, frame_start, running}
  wire [26:0] dut_vec = {hsync, vsync, de, x, y, line_start, frame_start, running};
  localparam logic [26:0] IDLE = {1'b1, 1'b1, 1'b0, 20'd0, 3'b000};

  function automatic logic [26:0] pk(input logic hs, vs, d, input int xx, yy,
                                     input logic l, f, r);
    return {hs, vs, d, xx[9:0], yy[9:0], l, f, r};
  endfunction

  task automatic chk(input string name, input logic [26:0] got, input logic [26:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s @cyc %0d: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b, expected hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b",
               name, cyc, got[26], got[25], got[24], got[23:14], got[13:4], got[2], got[1],
               got[0], exp[26], exp[25], exp[24], exp[23:14], exp[13:4], exp[2], exp[1],
               exp[0]);
    end
  endtask

  task automatic push(input int unsigned c, input string n, input logic [26:0] v);
    exp_t t;
    t.cyc  = c;
    t.name = n;
    t.v    = v;
    q.push_back(t);
  endtask

  // Expected raster position (h, v) relative to first-pixel cycle r, running=1.
  task automatic pp(input int unsigned r, input string n, input int h, input int v,
                    input logic hs, vs, d, input int xx, yy, input logic l, f);
    push(r + v * HT + h, n, pk(hs, vs, d, xx, yy, l, f, 1'b1));
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compares whenever the DUT reaches a cycle the scoreboard has a vector for.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL %s: vector for cyc %0d not checked (now %0d)", e.name, e.cyc, cyc);
        end else begin
          chk(e.name, dut_vec, e.v);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  int unsigned t0, r0, l0, t2, t3, tr;

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b1;
    push(2, "reset_idle_a", IDLE);
    push(3, "reset_idle_b", IDLE);
    wait_cyc(5);
    reset      = 1'b0;
    pll_locked = 1'b0;
    for (int i = 1; i <= 4; i++) push(5 + i * 500, "unlocked_idle", IDLE);

    // Lock-up: first edge sampling pll_locked high is t0; first pixel at t0+2+LS+1.
    wait_cyc(2010);
    pll_locked = 1'b1;
    t0 = cyc + 1;
    r0 = t0 + 2 + LS + 1;
    push(r0 - 1, "pre_start_idle", IDLE);
    pp(r0, "f0_origin",     0,  0, 1, 1, 1,  0, 0, 1, 1);
    pp(r0, "h1",            1,  0, 1, 1, 1,  1, 0, 0, 0);
    pp(r0, "h15_last_px",  15,  0, 1, 1, 1, 15, 0, 0, 0);
    pp(r0, "h16_blank",    16,  0, 1, 1, 0,  0, 0, 0, 0);
    pp(r0, "h19_fp_end",   19,  0, 1, 1, 0,  0, 0, 0, 0);
    pp(r0, "hs_first",     20,  0, 0, 1, 0,  0, 0, 0, 0);
    pp(r0, "hs_last",      25,  0, 0, 1, 0,  0, 0, 0, 0);
    pp(r0, "hs_end",       26,  0, 1, 1, 0,  0, 0, 0, 0);
    pp(r0, "h29_line_end", 29,  0, 1, 1, 0,  0, 0, 0, 0);
    pp(r0, "line1_start",   0,  1, 1, 1, 1,  0, 1, 1, 0);
    pp(r0, "mid_pixel",     5,  3, 1, 1, 1,  5, 3, 0, 0);
    pp(r0, "last_active",  15,  7, 1, 1, 1, 15, 7, 0, 0);
    pp(r0, "v8_blank",      0,  8, 1, 1, 0,  0, 0, 1, 0);
    pp(r0, "pre_vsync",    29,  9, 1, 1, 0,  0, 0, 0, 0);
    pp(r0, "vs_first",      0, 10, 1, 0, 0,  0, 0, 1, 0);
    pp(r0, "vs_with_hs",   22, 10, 0, 0, 0,  0, 0, 0, 0);
    pp(r0, "vs_last",      29, 11, 1, 0, 0,  0, 0, 0, 0);
    pp(r0, "vs_end",        0, 12, 1, 1, 0,  0, 0, 1, 0);
    pp(r0, "frame_end",    29, 14, 1, 1, 0,  0, 0, 0, 0);
    pp(r0, "f1_origin",     0, 15, 1, 1, 1,  0, 0, 1, 1);

    // Lock loss while showing (h=10, v=5) of frame 1: two more pixels, then idle.
    l0 = r0 + FR + 5 * HT + 10;
    wait_cyc(l0);
    pll_locked = 1'b0;
    push(l0 + 1, "loss_px11", pk(1, 1, 1, 11, 5, 0, 0, 1));
    push(l0 + 2, "loss_px12", pk(1, 1, 1, 12, 5, 0, 0, 1));
    push(l0 + 3, "loss_idle", IDLE);
    push(l0 + 10, "loss_idle_hold", IDLE);

    wait_cyc(l0 + 12);
    pll_locked = 1'b1;
    t2 = cyc + 1;
    push(t2 + 6, "relock_pre_idle", IDLE);
    push(t2 + 7, "relock_origin", pk(1, 1, 1, 0, 0, 1, 1, 1));
    push(t2 + 8, "relock_px1", pk(1, 1, 1, 1, 0, 0, 0, 1));

    // One-cycle lock glitch mid-settle must restart the full settle wait.
    wait_cyc(t2 + 20);
    pll_locked = 1'b0;
    push(t2 + 30, "drop_idle", IDLE);
    wait_cyc(t2 + 40);
    pll_locked = 1'b1;
    t3 = cyc + 1;
    push(t3 + 7, "glitch_no_early_start", IDLE);
    push(t3 + 10, "glitch_pre_idle", IDLE);
    push(t3 + 11, "glitch_origin", pk(1, 1, 1, 0, 0, 1, 1, 1));
    push(t3 + 12, "glitch_px1", pk(1, 1, 1, 1, 0, 0, 0, 1));
    tr = t3 + 11 + 40;
    push(tr, "pre_reset_px", pk(1, 1, 1, 10, 1, 0, 0, 1));
    wait_cyc(t3 + 2);
    pll_locked = 1'b0;
    wait_cyc(t3 + 3);
    pll_locked = 1'b1;

    // Async reset between clock edges: outputs must go idle with no edge.
    wait_cyc(tr);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_idle", dut_vec, IDLE);
    #2;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s: vector for cyc %0d never reached (now %0d)", e.name, e.cyc, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
